sc_datapath_sequencer: RTL and testbench
========================================

Name: sc_datapath_sequencer

Overview:
- Command-driven controller for the register-file/ALU/shift-register datapath (4 general regs, 2 fixed regs, BUSA/BUSB muxes, ALU, load/shift register, write decoder).
- Accepts one micro-command per valid/ready handshake and sequences the datapath control fields through execute, load, optional shift and write-back phases.
- Latches ALU flags and reports completion.
- Replaces per-operation hard-coded state chains; sits between a program/test source and the datapath.

Parameters:
- DATAWIDTH_DECODER_SELECTION, 3, write-decoder select width
- DATAWIDTH_MUX_SELECTION, 3, BUSA/BUSB mux select width
- DATAWIDTH_ALU_SELECTION, 4, ALU op width
- DATAWIDTH_REGSHIFTER_SELECTION, 2, shift-select width
- DATAWIDTH_SHIFT_COUNT, 2, shift-count field width (max 2^W-1 shift cycles)

Ports:
- SC_DPSEQ_CLOCK_50  in  1  clock, rising edge
- SC_DPSEQ_Reset_InHigh  in  1  asynchronous, active-high reset
- SC_DPSEQ_CmdValid_InHigh  in  1  command valid
- SC_DPSEQ_CmdReady_OutHigh  out  1  sequencer can accept
- SC_DPSEQ_CmdALUOp_In  in  4  ALU op (1000 ADD, 1001 SUB, ...)
- SC_DPSEQ_CmdSrcA_In  in  3  BUSA source (000-011 RegGen, 100-101 RegFIX)
- SC_DPSEQ_CmdSrcB_In  in  3  BUSB source, same coding
- SC_DPSEQ_CmdDest_In  in  2  destination RegGen_0..3
- SC_DPSEQ_CmdShiftDir_In  in  2  01 left, 10 right, 00/11 none
- SC_DPSEQ_CmdShiftCount_In  in  DATAWIDTH_SHIFT_COUNT  number of shift cycles
- SC_DPSEQ_Overflow_InLow, _Carry_InLow, _Negative_InLow, _Zero_InLow  in  1 each  ALU flags, active low
- SC_DPSEQ_DecoderSelectionWrite_Out  out  3  write decoder (111 = none)
- SC_DPSEQ_MUXSelectionBUSA_Out  out  3  BUSA mux
- SC_DPSEQ_MUXSelectionBUSB_Out  out  3  BUSB mux
- SC_DPSEQ_ALUSelection_Out  out  4  ALU op
- SC_DPSEQ_RegSHIFTERLoad_OutLow  out  1  0 = load shift register
- SC_DPSEQ_RegSHIFTERShiftSelection_OutLow  out  2  shift select
- SC_DPSEQ_Flags_Out  out  4  latched {V,C,N,Z}, active high
- SC_DPSEQ_Done_OutHigh  out  1  one-cycle completion pulse
- SC_DPSEQ_Error_OutHigh  out  1  one-cycle illegal-command pulse

Behaviour:
- NOP control vector: decoder 111, BUSA 111, BUSB 111, ALU 1111, load 1, shift 11. Driven in IDLE, ERR and under reset.
- Reset (async, immediate): state IDLE, NOP vector, Flags 0000, Done 0, Error 0, command register cleared, CmdReady 1.
- CmdReady = 1 only in IDLE. Command is captured on a rising edge with Valid & Ready. Inputs are ignored otherwise.
- States and transitions:
  - IDLE -> EXEC on accept; -> ERR on accept if SrcA or SrcB is in {110,111}.
  - EXEC (1 cycle): BUSA = SrcA, BUSB = SrcB, ALU = op, load 1, decoder 111. -> LOAD.
  - LOAD (1 cycle): same mux/ALU, load 0. Flags register <= ~{Overflow,Carry,Negative,Zero} on the exiting edge. -> SHIFT if dir is in {01,10} and count != 0, else WRITE.
  - SHIFT (count cycles): mux/ALU NOP, load 1, shift = dir. A down-counter is loaded with count at LOAD exit. -> WRITE when the counter reaches 1.
  - WRITE (1 cycle): decoder = {1'b0, Dest}, rest NOP, Done 1. -> IDLE.
  - ERR (1 cycle): NOP vector, Error 1, no load, no write, flags unchanged. -> IDLE.
- Latency from accept edge to Done: 3 + n cycles (n = effective shift count). Next accept is possible on the edge ending the WRITE/ERR cycle +1; no overlap between commands.
- Outputs are a registered function of state plus the captured command. They never depend combinationally on Cmd inputs.
- ALU codes 0101-0111 and 1100-1111 are legal (pass-A) and are not flagged.
- Flags hold between LOADs. A reset mid-operation aborts with no write and clears Flags.
- Valid deasserting while Ready=0 has no effect. The captured command is used.

Decomposition:
- Package sc_dpseq_pkg:
  - state encoding localparams (IDLE, EXEC, LOAD, SHIFT, WRITE, ERR)
  - NOP field constants
  - ALU op codes
  - mux source codes
  - shift-direction codes
- Sub-module sc_dpseq_shiftcnt: loadable down-counter with terminal-count flag. Everything else stays in the top.

Test Plan:
- Reset, then ADD Dest=11, SrcA=100, SrcB=101, dir=00:
  - accept cycle +1: BUSA=100, BUSB=101, ALU=1000, load=1
  - +2: load=0
  - +3: decoder=011, Done=1
  - +4: CmdReady=1, NOP vector
- XOR Dest=00, SrcA=000, SrcB=001, dir=01, count=2: EXEC, LOAD, two cycles shift=01, then WRITE decoder=000 with Done at +5. Shift=11 everywhere else.
- SrcB=110: Error=1 at +1; decoder stays 111 and load stays 1 throughout; CmdReady=1 at +2; Flags unchanged.
- During LOAD drive Zero_InLow=0, other flags 1: Flags_Out=0001 from +3. Flags hold through a following command's EXEC, then update at its LOAD.
- Assert reset in second SHIFT cycle of a count=3 command: outputs go to NOP and Flags=0000 without waiting for a clock edge; no decoder write ever occurs; CmdReady=1 after release.
- Valid held high with two queued commands: second accepted only when CmdReady reasserts; exactly one WRITE and one Done per command, in order.

Source files
------------

// File: rtl/sc_dpseq_pkg.sv
// sc_dpseq_pkg: shared encodings for the datapath sequencer
package sc_dpseq_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_EXEC  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;
  localparam logic [2:0] NOP_DEC   = 3'b111;
  localparam logic [2:0] NOP_MUX   = 3'b111;
  localparam logic [3:0] NOP_ALU   = 4'b1111;
  localparam logic       NOP_LOAD  = 1'b1;
  localparam logic [1:0] NOP_SHIFT = 2'b11;
  localparam logic [3:0] ALU_ADD = 4'b1000;
  localparam logic [3:0] ALU_SUB = 4'b1001;
  localparam logic [2:0] SRC_GEN0 = 3'b000;
  localparam logic [2:0] SRC_FIX1 = 3'b101;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  typedef struct packed {
    logic [3:0] op;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic [1:0] dest;
    logic [1:0] dir;
  } cmd_t;
  // codes past the last fixed register select nothing on the bus
  function automatic logic is_bad_src(input logic [2:0] s);
    return s > SRC_FIX1;
  endfunction
endpackage

// File: rtl/sc_dpseq_shiftcnt.sv
// sc_dpseq_shiftcnt: loadable down-counter flagging the last shift cycle
module sc_dpseq_shiftcnt #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  assign tc_o = cnt_q == W'(1);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sc_datapath_sequencer.sv
// sc_datapath_sequencer: sequences one micro-command through execute, load,
// optional shift and write-back phases of the register/ALU/shifter datapath
module sc_datapath_sequencer import sc_dpseq_pkg::*; #(
  parameter int DATAWIDTH_DECODER_SELECTION    = 3,
  parameter int DATAWIDTH_MUX_SELECTION        = 3,
  parameter int DATAWIDTH_ALU_SELECTION        = 4,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter int DATAWIDTH_SHIFT_COUNT          = 2
) (
  input  logic                                      SC_DPSEQ_CLOCK_50,
  input  logic                                      SC_DPSEQ_Reset_InHigh,
  input  logic                                      SC_DPSEQ_CmdValid_InHigh,
  output logic                                      SC_DPSEQ_CmdReady_OutHigh,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_DPSEQ_CmdALUOp_In,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DPSEQ_CmdSrcA_In,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DPSEQ_CmdSrcB_In,
  input  logic [1:0]                                SC_DPSEQ_CmdDest_In,
  input  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_DPSEQ_CmdShiftDir_In,
  input  logic [DATAWIDTH_SHIFT_COUNT-1:0]          SC_DPSEQ_CmdShiftCount_In,
  input  logic                                      SC_DPSEQ_Overflow_InLow,
  input  logic                                      SC_DPSEQ_Carry_InLow,
  input  logic                                      SC_DPSEQ_Negative_InLow,
  input  logic                                      SC_DPSEQ_Zero_InLow,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_DPSEQ_DecoderSelectionWrite_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DPSEQ_MUXSelectionBUSA_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DPSEQ_MUXSelectionBUSB_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_DPSEQ_ALUSelection_Out,
  output logic                                      SC_DPSEQ_RegSHIFTERLoad_OutLow,
  output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_DPSEQ_RegSHIFTERShiftSelection_OutLow,
  output logic [3:0]                                SC_DPSEQ_Flags_Out,
  output logic                                      SC_DPSEQ_Done_OutHigh,
  output logic                                      SC_DPSEQ_Error_OutHigh
);
  logic [2:0] state_q, state_d;
  cmd_t cmd_q, cmd_d;
  logic [DATAWIDTH_SHIFT_COUNT-1:0] count_q;
  logic [3:0] flags_q;
  logic accept, bad_src, do_shift, tc, in_alu;
  assign cmd_d = '{op: SC_DPSEQ_CmdALUOp_In, src_a: SC_DPSEQ_CmdSrcA_In,
                   src_b: SC_DPSEQ_CmdSrcB_In, dest: SC_DPSEQ_CmdDest_In,
                   dir: SC_DPSEQ_CmdShiftDir_In};
  assign accept = SC_DPSEQ_CmdValid_InHigh && state_q == ST_IDLE;
  assign bad_src = is_bad_src(SC_DPSEQ_CmdSrcA_In) || is_bad_src(SC_DPSEQ_CmdSrcB_In);
  assign do_shift = (cmd_q.dir == DIR_LEFT || cmd_q.dir == DIR_RIGHT) && count_q != '0;
  assign in_alu = state_q == ST_EXEC || state_q == ST_LOAD;
  always_ff @(posedge SC_DPSEQ_CLOCK_50 or posedge SC_DPSEQ_Reset_InHigh)
    if (SC_DPSEQ_Reset_InHigh) state_q <= ST_IDLE;
    else state_q <= state_d;
  always_ff @(posedge SC_DPSEQ_CLOCK_50 or posedge SC_DPSEQ_Reset_InHigh)
    if (SC_DPSEQ_Reset_InHigh) begin
      cmd_q   <= '0;
      count_q <= '0;
      flags_q <= '0;
    end else begin
      if (accept) begin
        cmd_q   <= cmd_d;
        count_q <= SC_DPSEQ_CmdShiftCount_In;
      end
      if (state_q == ST_LOAD)
        flags_q <= ~{SC_DPSEQ_Overflow_InLow, SC_DPSEQ_Carry_InLow,
                     SC_DPSEQ_Negative_InLow, SC_DPSEQ_Zero_InLow};
    end
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:  state_d = accept ? (bad_src ? ST_ERR : ST_EXEC) : ST_IDLE;
      ST_EXEC:  state_d = ST_LOAD;
      ST_LOAD:  state_d = do_shift ? ST_SHIFT : ST_WRITE;
      ST_SHIFT: state_d = tc ? ST_WRITE : ST_SHIFT;
      default:  state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    SC_DPSEQ_CmdReady_OutHigh                = state_q == ST_IDLE;
    SC_DPSEQ_MUXSelectionBUSA_Out            = in_alu ? cmd_q.src_a : NOP_MUX;
    SC_DPSEQ_MUXSelectionBUSB_Out            = in_alu ? cmd_q.src_b : NOP_MUX;
    SC_DPSEQ_ALUSelection_Out                = in_alu ? cmd_q.op : NOP_ALU;
    SC_DPSEQ_RegSHIFTERLoad_OutLow           = state_q == ST_LOAD ? ~NOP_LOAD : NOP_LOAD;
    SC_DPSEQ_RegSHIFTERShiftSelection_OutLow = state_q == ST_SHIFT ? cmd_q.dir : NOP_SHIFT;
    SC_DPSEQ_DecoderSelectionWrite_Out       = state_q == ST_WRITE ? {1'b0, cmd_q.dest} : NOP_DEC;
    SC_DPSEQ_Flags_Out                       = flags_q;
    SC_DPSEQ_Done_OutHigh                    = state_q == ST_WRITE;
    SC_DPSEQ_Error_OutHigh                   = state_q == ST_ERR;
  end
  // the shift length is taken from the captured command when LOAD is left
  sc_dpseq_shiftcnt #(.W(DATAWIDTH_SHIFT_COUNT)) u_shiftcnt (
    .clk_i  (SC_DPSEQ_CLOCK_50),
    .rst_i  (SC_DPSEQ_Reset_InHigh),
    .load_i (state_q == ST_LOAD),
    .dec_i  (state_q == ST_SHIFT),
    .val_i  (count_q),
    .tc_o   (tc)
  );
endmodule

// File: tb/tb_sc_datapath_sequencer.sv
// tb_sc_datapath_sequencer: per-cycle trace checks of the sequencer against a
// phase-list model of each command
module tb_sc_datapath_sequencer;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0;
  logic [3:0] op_i = '0;
  logic [2:0] sa_i = '0, sb_i = '0;
  logic [1:0] de_i = '0, dr_i = '0, cn_i = '0;
  logic [3:0] fi = 4'hF;
  logic rdy, ld, done, err;
  logic [2:0] dec, busa, busb;
  logic [3:0] alu, flags;
  logic [1:0] sh;
  logic [22:0] obs;
  logic [22:0] exp_q[$];
  logic [3:0] fl_exp = '0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sc_datapath_sequencer dut (
    .SC_DPSEQ_CLOCK_50(clk), .SC_DPSEQ_Reset_InHigh(rst),
    .SC_DPSEQ_CmdValid_InHigh(valid), .SC_DPSEQ_CmdReady_OutHigh(rdy),
    .SC_DPSEQ_CmdALUOp_In(op_i), .SC_DPSEQ_CmdSrcA_In(sa_i), .SC_DPSEQ_CmdSrcB_In(sb_i),
    .SC_DPSEQ_CmdDest_In(de_i), .SC_DPSEQ_CmdShiftDir_In(dr_i), .SC_DPSEQ_CmdShiftCount_In(cn_i),
    .SC_DPSEQ_Overflow_InLow(fi[3]), .SC_DPSEQ_Carry_InLow(fi[2]),
    .SC_DPSEQ_Negative_InLow(fi[1]), .SC_DPSEQ_Zero_InLow(fi[0]),
    .SC_DPSEQ_DecoderSelectionWrite_Out(dec), .SC_DPSEQ_MUXSelectionBUSA_Out(busa),
    .SC_DPSEQ_MUXSelectionBUSB_Out(busb), .SC_DPSEQ_ALUSelection_Out(alu),
    .SC_DPSEQ_RegSHIFTERLoad_OutLow(ld), .SC_DPSEQ_RegSHIFTERShiftSelection_OutLow(sh),
    .SC_DPSEQ_Flags_Out(flags), .SC_DPSEQ_Done_OutHigh(done), .SC_DPSEQ_Error_OutHigh(err)
  );

  assign obs = {dec, busa, busb, alu, ld, sh, done, err, rdy, flags};

  function automatic logic [22:0] mk(input logic [2:0] d, a, b, input logic [3:0] al,
                                     input logic l, input logic [1:0] s,
                                     input logic dn, er, rd, input logic [3:0] f);
    return {d, a, b, al, l, s, dn, er, rd, f};
  endfunction

  // Expected cycle-by-cycle outputs after the accept edge, ending with the idle cycle.
  task automatic model_cmd(input logic [3:0] op, input logic [2:0] sa, sb,
                           input logic [1:0] de, dr, cn, input logic [3:0] fin);
    int n;
    exp_q.delete();
    if (sa >= 3'd6 || sb >= 3'd6)
      exp_q.push_back(mk(3'd7, 3'd7, 3'd7, 4'hF, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, fl_exp));
    else begin
      n = (dr == 2'b01 || dr == 2'b10) ? int'(cn) : 0;
      exp_q.push_back(mk(3'd7, sa, sb, op, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, fl_exp));
      exp_q.push_back(mk(3'd7, sa, sb, op, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, fl_exp));
      fl_exp = ~fin;
      repeat (n) exp_q.push_back(mk(3'd7, 3'd7, 3'd7, 4'hF, 1'b1, dr, 1'b0, 1'b0, 1'b0, fl_exp));
      exp_q.push_back(mk({1'b0, de}, 3'd7, 3'd7, 4'hF, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, fl_exp));
    end
    exp_q.push_back(mk(3'd7, 3'd7, 3'd7, 4'hF, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, fl_exp));
  endtask

  // Drive one command from idle; after the accept edge the command inputs are scrambled
  // so the captured copy is the only one the sequencer may use.
  task automatic send(input logic [3:0] op, input logic [2:0] sa, sb,
                      input logic [1:0] de, dr, cn, input logic [3:0] fin);
    @(negedge clk);
    op_i = op; sa_i = sa; sb_i = sb; de_i = de; dr_i = dr; cn_i = cn; fi = fin; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    op_i = 4'($urandom); sa_i = 3'($urandom); sb_i = 3'($urandom);
    de_i = 2'($urandom); dr_i = 2'($urandom); cn_i = 2'($urandom);
    model_cmd(op, sa, sb, de, dr, cn, fin);
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (obs !== mk(3'd7, 3'd7, 3'd7, 4'hF, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 4'h0)) begin
      errors++; $display("FAIL reset_hold got=%h exp=idle", obs);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== mk(3'd7, 3'd7, 3'd7, 4'hF, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 4'h0)) begin
      errors++; $display("FAIL reset_release got=%h exp=idle", obs);
    end
  endtask

  task automatic test_add;
    send(4'b1000, 3'b100, 3'b101, 2'b11, 2'b00, 2'd3, 4'hF);
    foreach (exp_q[i]) begin
      @(negedge clk); checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL add cyc+%0d got=%h exp=%h", i + 1, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_shift;
    send(4'b0100, 3'b000, 3'b001, 2'b00, 2'b01, 2'd2, 4'hF);
    foreach (exp_q[i]) begin
      @(negedge clk); checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL shift_left2 cyc+%0d got=%h exp=%h", i + 1, obs, exp_q[i]);
      end
    end
    send(4'b1001, 3'b010, 3'b011, 2'b01, 2'b10, 2'd0, 4'hF);
    foreach (exp_q[i]) begin
      @(negedge clk); checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL shift_count0 cyc+%0d got=%h exp=%h", i + 1, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_flags;
    send(4'b1000, 3'b001, 3'b010, 2'b10, 2'b00, 2'd0, 4'b1110);
    foreach (exp_q[i]) begin
      @(negedge clk); checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL flags_zero cyc+%0d got=%h exp=%h", i + 1, obs, exp_q[i]);
      end
    end
    send(4'b1001, 3'b011, 3'b100, 2'b01, 2'b10, 2'd1, 4'b0111);
    foreach (exp_q[i]) begin
      @(negedge clk); checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL flags_update cyc+%0d got=%h exp=%h", i + 1, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_error;
    send(4'b1000, 3'b000, 3'b110, 2'b10, 2'b01, 2'd2, 4'b0000);
    foreach (exp_q[i]) begin
      @(negedge clk); checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL error_srcb cyc+%0d got=%h exp=%h", i + 1, obs, exp_q[i]);
      end
    end
    send(4'b1111, 3'b111, 3'b000, 2'b11, 2'b00, 2'd0, 4'b0000);
    foreach (exp_q[i]) begin
      @(negedge clk); checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL error_srca cyc+%0d got=%h exp=%h", i + 1, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    send(4'b1001, 3'b001, 3'b010, 2'b10, 2'b10, 2'd3, 4'b0101);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL rstmid_pre cyc+%0d got=%h exp=%h", i + 1, obs, exp_q[i]);
      end
    end
    #2 rst = 1'b1;
    fl_exp = '0;
    #1;
    checks++;
    if (obs !== mk(3'd7, 3'd7, 3'd7, 4'hF, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 4'h0)) begin
      errors++; $display("FAIL rstmid_async got=%h exp=idle", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); checks++;
      if (obs !== mk(3'd7, 3'd7, 3'd7, 4'hF, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 4'h0)) begin
        errors++; $display("FAIL rstmid_after cyc%0d got=%h exp=idle", i, obs);
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    op_i = 4'b1000; sa_i = 3'b000; sb_i = 3'b001; de_i = 2'b01; dr_i = 2'b01; cn_i = 2'd1;
    fi = 4'b1010; valid = 1'b1;
    @(posedge clk);
    #1;
    op_i = 4'b1001; sa_i = 3'b101; sb_i = 3'b011; de_i = 2'b10; dr_i = 2'b10; cn_i = 2'd2;
    model_cmd(4'b1000, 3'b000, 3'b001, 2'b01, 2'b01, 2'd1, 4'b1010);
    foreach (exp_q[i]) begin
      @(negedge clk); checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL b2b_first cyc+%0d got=%h exp=%h", i + 1, obs, exp_q[i]);
      end
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    model_cmd(4'b1001, 3'b101, 3'b011, 2'b10, 2'b10, 2'd2, 4'b1010);
    foreach (exp_q[i]) begin
      @(negedge clk); checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL b2b_second cyc+%0d got=%h exp=%h", i + 1, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 40; k++) begin
      send(4'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom));
      foreach (exp_q[i]) begin
        @(negedge clk); checks++;
        if (obs !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d cyc+%0d got=%h exp=%h", k, i + 1, obs, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_shift;
    test_flags;
    test_error;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end
endmodule
